seq_signed_divider: RTL

Multi-cycle signed integer divider: the inverse datapath of the tree multiplier, recovering a factor from a product. It accepts a WIDTH-bit signed dividend and divisor on a start pulse. It runs a radix-2 restoring iteration over WIDTH cycles and returns the truncated quotient and remainder with a one-cycle done pulse. It sits beside the multiplier in the arithmetic block and shares the multiplier's clk/reset/en control style.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_step.sv | 29 ++
 rtl/seq_signed_divider.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared constants for the arithmetic block: default operand width and the
// divider state encoding.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ITER = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_ITER = ITER,
        ST_FIX  = FIX
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift {rem, quo} left, trial-subtract
// the divisor magnitude, keep the difference when it does not go negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH:0]   dvs,
    output logic [WIDTH:0]   next_rem,
    output logic [WIDTH-1:0] next_quo
);

    logic [WIDTH+1:0] shifted_s;
    logic [WIDTH+1:0] diff_s;

    // Trial subtraction carried one bit wider so its sign bit marks a borrow.
    always_comb begin
        shifted_s = {rem, quo[WIDTH-1]};
        diff_s    = shifted_s - {1'b0, dvs};
        if (diff_s[WIDTH+1]) begin
            next_rem = shifted_s[WIDTH:0];
            next_quo = {quo[WIDTH-2:0], 1'b0};
        end else begin
            next_rem = diff_s[WIDTH:0];
            next_quo = {quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider: magnitudes are divided by a restoring iteration
// over WIDTH cycles, then signs are applied so results match Verilog / and %.
module seq_signed_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int               CW    = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL1  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO  = {WIDTH{1'b0}};
    localparam logic [WIDTH:0]   ZERO1 = {(WIDTH+1){1'b0}};
    localparam logic [CW-1:0]    CNT0  = {CW{1'b0}};
    localparam logic [CW-1:0]    CNT1  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
        return ~x + ONE;
    endfunction

    // Unsigned magnitude; WIDTH bits suffice because 2^(WIDTH-1) fits unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? neg(x) : x;
    endfunction

    div_state_e       state_r, state_nxt_s;
    logic [CW-1:0]    count_r;
    logic [WIDTH:0]   rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH:0]   dvs_r;
    logic [WIDTH-1:0] dividend_r;
    logic             neg_q_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             dbz_r;

    logic             load_s;
    logic             iter_s;
    logic             fix_s;
    logic [WIDTH:0]   step_rem_s;
    logic [WIDTH-1:0] step_quo_s;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .dvs      (dvs_r),
        .next_rem (step_rem_s),
        .next_quo (step_quo_s)
    );

    // Next-state and per-state control strobes.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        iter_s      = 1'b0;
        fix_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    load_s      = 1'b1;
                    state_nxt_s = ST_ITER;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ITER: begin
                iter_s = 1'b1;
                if (count_r == CNT0) begin
                    state_nxt_s = ST_FIX;
                end else begin
                    state_nxt_s = ST_ITER;
                end
            end
            ST_FIX: begin
                fix_s       = 1'b1;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers; en=0 holds everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            count_r     <= CNT0;
            rem_r       <= ZERO1;
            quo_r       <= ZERO;
            dvs_r       <= ZERO1;
            dividend_r  <= ZERO;
            neg_q_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= ZERO;
            remainder_r <= ZERO;
            dbz_r       <= 1'b0;
        end else if (en) begin
            state_r <= state_nxt_s;
            done_r  <= fix_s;
            if (load_s) begin
                count_r    <= CNT_LAST;
                rem_r      <= ZERO1;
                quo_r      <= mag(dividend);
                dvs_r      <= {1'b0, mag(divisor)};
                dividend_r <= dividend;
                neg_q_r    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                busy_r     <= 1'b1;
            end else if (iter_s) begin
                rem_r   <= step_rem_s;
                quo_r   <= step_quo_s;
                count_r <= count_r - CNT1;
            end else if (fix_s) begin
                busy_r <= 1'b0;
                // Zero divisor: the iteration ran anyway for fixed latency; override.
                if (dvs_r == ZERO1) begin
                    quotient_r  <= ALL1;
                    remainder_r <= dividend_r;
                    dbz_r       <= 1'b1;
                end else begin
                    quotient_r  <= neg_q_r ? neg(quo_r) : quo_r;
                    remainder_r <= dividend_r[WIDTH-1] ? neg(rem_r[WIDTH-1:0])
                                                       : rem_r[WIDTH-1:0];
                    dbz_r       <= 1'b0;
                end
            end
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;

endmodule
